// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle arithmetic/logic/compare/branch ops and bit-serial shifts,
// with valid/ready handshakes on the request and result sides.
module alu_multicycle #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            in_op,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic                  out_zero,
    output logic                  out_bcond,
    output logic                  out_err
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00110;
    localparam logic [4:0] OP_LUI  = 5'b01000;
    localparam logic [4:0] OP_SRL  = 5'b01010;
    localparam logic [4:0] OP_SRA  = 5'b01011;
    localparam logic [4:0] OP_SLL  = 5'b01101;
    localparam logic [4:0] OP_SLT  = 5'b10110;
    localparam logic [4:0] OP_SLTU = 5'b10111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BNE  = 5'b10001;
    localparam logic [4:0] OP_BLT  = 5'b10010;
    localparam logic [4:0] OP_BGE  = 5'b10011;
    localparam logic [4:0] OP_BLTU = 5'b10100;
    localparam logic [4:0] OP_BGEU = 5'b10101;

    localparam logic [DATA_WIDTH-1:0]  ZERO_W = {DATA_WIDTH{1'b0}};
    localparam logic [SHAMT_WIDTH-1:0] ZERO_S = {SHAMT_WIDTH{1'b0}};
    localparam logic [SHAMT_WIDTH-1:0] ONE_S  = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_r;
    logic [4:0]              op_r;
    logic [DATA_WIDTH-1:0]   acc_r;
    logic [SHAMT_WIDTH-1:0]  cnt_r;

    logic [DATA_WIDTH-1:0]   res_s;
    logic                    bcond_s;
    logic                    branch_s;
    logic                    err_s;
    logic                    shift_s;
    logic                    eq_s;
    logic                    lt_s;
    logic                    ltu_s;
    logic [SHAMT_WIDTH-1:0]  shamt_s;
    logic [DATA_WIDTH-1:0]   acc_next_s;

    assign eq_s    = (in_a == in_b);
    assign lt_s    = ($signed(in_a) < $signed(in_b));
    assign ltu_s   = (in_a < in_b);
    assign shamt_s = in_b[SHAMT_WIDTH-1:0];

    // Single-cycle result for the request currently presented; shifts only yield their shamt==0 value here.
    always_comb begin
        res_s    = ZERO_W;
        bcond_s  = 1'b0;
        branch_s = 1'b0;
        err_s    = 1'b0;
        shift_s  = 1'b0;
        case (in_op)
            OP_ADD:  res_s = in_a + in_b;
            OP_SUB:  res_s = in_a - in_b;
            OP_AND:  res_s = in_a & in_b;
            OP_OR:   res_s = in_a | in_b;
            OP_XOR:  res_s = in_a ^ in_b;
            OP_LUI:  res_s = in_b;
            OP_SRL, OP_SRA, OP_SLL: begin
                shift_s = 1'b1;
                res_s   = in_a;
            end
            OP_SLT:  res_s = {{(DATA_WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: res_s = {{(DATA_WIDTH-1){1'b0}}, ltu_s};
            OP_BEQ:  begin branch_s = 1'b1; bcond_s = eq_s;   end
            OP_BNE:  begin branch_s = 1'b1; bcond_s = !eq_s;  end
            OP_BLT:  begin branch_s = 1'b1; bcond_s = lt_s;   end
            OP_BGE:  begin branch_s = 1'b1; bcond_s = !lt_s;  end
            OP_BLTU: begin branch_s = 1'b1; bcond_s = ltu_s;  end
            OP_BGEU: begin branch_s = 1'b1; bcond_s = !ltu_s; end
            default: err_s = 1'b1;
        endcase
        if (branch_s) begin
            res_s = {{(DATA_WIDTH-1){1'b0}}, bcond_s};
        end else begin
            res_s = res_s;
        end
    end

    // One-bit shift step for the latched shift opcode.
    always_comb begin
        acc_next_s = acc_r;
        case (op_r)
            OP_SRL:  acc_next_s = {1'b0, acc_r[DATA_WIDTH-1:1]};
            OP_SRA:  acc_next_s = {acc_r[DATA_WIDTH-1], acc_r[DATA_WIDTH-1:1]};
            OP_SLL:  acc_next_s = {acc_r[DATA_WIDTH-2:0], 1'b0};
            default: acc_next_s = acc_r;
        endcase
    end

    // Control FSM with all handshake and result outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            op_r       <= 5'b00000;
            acc_r      <= ZERO_W;
            cnt_r      <= ZERO_S;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_result <= ZERO_W;
            out_zero   <= 1'b1;
            out_bcond  <= 1'b0;
            out_err    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (shift_s && (shamt_s != ZERO_S)) begin
                            state_r <= SHIFT;
                            op_r    <= in_op;
                            acc_r   <= in_a;
                            cnt_r   <= shamt_s;
                        end else begin
                            state_r    <= DONE;
                            out_valid  <= 1'b1;
                            out_result <= res_s;
                            out_zero   <= (res_s == ZERO_W);
                            out_bcond  <= bcond_s;
                            out_err    <= err_s;
                        end
                    end
                end
                SHIFT: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r - ONE_S;
                    if (cnt_r == ONE_S) begin
                        state_r    <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= acc_next_s;
                        out_zero   <= (acc_next_s == ZERO_W);
                        out_bcond  <= 1'b0;
                        out_err    <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r   <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle with hand-computed expected results.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_bcond;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    alu_multicycle #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_bcond  (out_bcond),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request, wait for its result and compare; lat = edges after the accept edge.
    task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic bc,
                       input logic err, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = 32'hDEADBEEF; in_b = 32'h0000001F;
        while (!out_valid && n < 100) begin
            if (in_ready) begin
                chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
            end
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_res"}, out_result, res);
        chk({tag, "_zero"}, {31'd0, out_zero}, {31'd0, (res == 32'd0)});
        chk({tag, "_bc"}, {31'd0, out_bcond}, {31'd0, bc});
        chk({tag, "_err"}, {31'd0, out_err}, {31'd0, err});
    endtask

    // Complete the result handshake and confirm the unit is ready again next cycle.
    task automatic take(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_ovl"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_irdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 5'd0; in_a = 32'd0; in_b = 32'd0;
        #12;
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        chk("rst_ovl", {31'd0, out_valid}, 32'd0);
        chk("rst_res", out_result, 32'd0);
        chk("rst_zero", {31'd0, out_zero}, 32'd1);
        chk("rst_bc", {31'd0, out_bcond}, 32'd0);
        chk("rst_err", {31'd0, out_err}, 32'd0);
        @(negedge clk); reset_n = 1'b1;

        run("add",  5'b00000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 0);  take("add");
        run("sub",  5'b00001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0, 1'b0, 0);  take("sub");
        run("and",  5'b00010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 0);  take("and");
        run("or",   5'b00011, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0, 1'b0, 0);  take("or");
        run("xor",  5'b00110, 32'hAAAAAAAA, 32'hFFFF0000, 32'h5555AAAA, 1'b0, 1'b0, 0);  take("xor");
        run("lui",  5'b01000, 32'h00001234, 32'hABCDE000, 32'hABCDE000, 1'b0, 1'b0, 0);  take("lui");
        run("slt",  5'b10110, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 0);  take("slt");
        run("sltu", 5'b10111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 0);  take("sltu");
        run("sll0", 5'b01101, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0, 1'b0, 0);  take("sll0");
        run("sll4", 5'b01101, 32'h00000001, 32'h00000004, 32'h00000010, 1'b0, 1'b0, 4);  take("sll4");
        run("sra",  5'b01011, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 31); take("sra");
        run("srl",  5'b01010, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0, 1'b0, 31); take("srl");
        run("blt",  5'b10010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 0);  take("blt");
        run("bltu", 5'b10100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 0);  take("bltu");
        run("beq",  5'b10000, 32'h00000005, 32'h00000005, 32'h00000001, 1'b1, 1'b0, 0);  take("beq");
        run("bne",  5'b10001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 0);  take("bne");
        run("bge",  5'b10011, 32'h80000000, 32'h7FFFFFFF, 32'h00000000, 1'b0, 1'b0, 0);  take("bge");
        run("bgeu", 5'b10101, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 0);  take("bgeu");

        // Backpressure: result must hold while new requests are pulsed and ignored.
        run("bp", 5'b00000, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_op = 5'b00001; in_a = 32'h00000100; in_b = 32'h00000001;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("bp_ovl", {31'd0, out_valid}, 32'd1);
            chk("bp_res", out_result, 32'h00000007);
            chk("bp_rdy", {31'd0, in_ready}, 32'd0);
        end
        take("bp");

        // Reset in the middle of a 20-bit shift.
        @(negedge clk);
        in_op = 5'b01101; in_a = 32'h00000001; in_b = 32'h00000014; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_rdy", {31'd0, in_ready}, 32'd1);
        chk("ar_ovl", {31'd0, out_valid}, 32'd0);
        chk("ar_res", out_result, 32'd0);
        chk("ar_zero", {31'd0, out_zero}, 32'd1);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ar_ovl2", {31'd0, out_valid}, 32'd0);
        run("bad", 5'b11111, 32'h00000012, 32'h00000034, 32'h00000000, 1'b0, 1'b1, 0); take("bad");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
